// File: rtl/gpu_host_bridge.sv
// gpu_host_bridge: single-outstanding host command bridge to the GPU memory
// PCIe-side request/ready interface, plus a sticky GPU-completion interrupt.
// Optional feature: define GPU_HOST_BRIDGE_TIMEOUT_EN to add a 16-bit wait
// counter that aborts a request after TIMEOUT_CYCLES cycles without ready and
// reports it with rsp_error = 1.
module gpu_host_bridge #(
  parameter int MEM_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clock,
  input  logic                      reset_n,
  // host command / response
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [MEM_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [MEM_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [MEM_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_error,
  // GPU memory side
  output logic                      pcie_read_request,
  output logic                      pcie_write_request,
  output logic [MEM_ADDR_WIDTH-1:0] pcie_read_addr,
  output logic [MEM_ADDR_WIDTH-1:0] pcie_write_addr,
  output logic [MEM_DATA_WIDTH-1:0] pcie_write_data,
  input  logic                      pcie_read_ready,
  input  logic                      pcie_write_ready,
  input  logic [MEM_DATA_WIDTH-1:0] pcie_read_data,
  // completion interrupt
  input  logic                      gpu_done,
  input  logic                      irq_clear,
  output logic                      done_irq
);

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RESP} state_t;

  state_t                    state, state_nxt;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [MEM_DATA_WIDTH-1:0] wdata_q;
  logic [MEM_DATA_WIDTH-1:0] rdata_q, rdata_nxt;
  logic                      accept;
  logic                      timeout_hit;
  logic                      gpu_done_q;
  logic                      done_rise;

  assign accept = cmd_valid && (state == IDLE);

`ifdef GPU_HOST_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic        err_q, err_nxt;
  logic        waiting;

  // a request cycle without its matching ready counts as a wait cycle
  assign waiting = ((state == WR_REQ) && !pcie_write_ready) ||
                   ((state == RD_REQ) && !pcie_read_ready);
  // last permitted wait cycle: the counter would reach TIMEOUT_CYCLES here
  assign timeout_hit = waiting && (wait_cnt == TO_LAST);

  // wait counter: zeroed in IDLE so every request starts from 0
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            wait_cnt <= '0;
    else if (state == IDLE)  wait_cnt <= '0;
    else if (waiting)        wait_cnt <= wait_cnt + 16'd1;
  end

  // error flag is written only on the transition into RESP, held there
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_nxt;
  end

  assign rsp_error = err_q;
`else
  // the timeout parameter has no effect in this build
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign rsp_error          = 1'b0;
`endif

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next state and response data; readies are only looked at in their own state
  always_comb begin
    state_nxt = state;
    rdata_nxt = rdata_q;
`ifdef GPU_HOST_BRIDGE_TIMEOUT_EN
    err_nxt   = err_q;
`endif
    unique case (state)
      IDLE: begin
        if (cmd_valid) state_nxt = cmd_write ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        if (pcie_write_ready) begin
          state_nxt = RESP;
          rdata_nxt = '0;
`ifdef GPU_HOST_BRIDGE_TIMEOUT_EN
          err_nxt   = 1'b0;
`endif
        end else if (timeout_hit) begin
          state_nxt = RESP;
          rdata_nxt = '0;
`ifdef GPU_HOST_BRIDGE_TIMEOUT_EN
          err_nxt   = 1'b1;
`endif
        end
      end
      RD_REQ: begin
        if (pcie_read_ready) begin
          state_nxt = RESP;
          rdata_nxt = pcie_read_data;
`ifdef GPU_HOST_BRIDGE_TIMEOUT_EN
          err_nxt   = 1'b0;
`endif
        end else if (timeout_hit) begin
          state_nxt = RESP;
          rdata_nxt = '0;
`ifdef GPU_HOST_BRIDGE_TIMEOUT_EN
          err_nxt   = 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // command capture on accept; held stable for the whole request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
    end
  end

  // response data register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_nxt;
  end

  // strobes decode straight from the state flop so reset drops them at once
  assign cmd_ready          = (state == IDLE);
  assign rsp_valid          = (state == RESP);
  assign rsp_rdata          = rdata_q;
  assign pcie_write_request = (state == WR_REQ);
  assign pcie_read_request  = (state == RD_REQ);
  assign pcie_write_addr    = addr_q;
  assign pcie_read_addr     = addr_q;
  assign pcie_write_data    = wdata_q;

  assign done_rise = gpu_done && !gpu_done_q;

  // sticky interrupt: a new rising edge beats a simultaneous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gpu_done_q <= 1'b0;
      done_irq   <= 1'b0;
    end else begin
      gpu_done_q <= gpu_done;
      if (done_rise)      done_irq <= 1'b1;
      else if (irq_clear) done_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpu_host_bridge.sv
// Directed bench for gpu_host_bridge. Inputs change and outputs are sampled on
// the falling clock edge, so every check sees state settled after a rising edge.
module tb_gpu_host_bridge;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 4;

  logic          clock, reset_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic          pcie_read_request, pcie_write_request;
  logic [AW-1:0] pcie_read_addr, pcie_write_addr;
  logic [DW-1:0] pcie_write_data, pcie_read_data;
  logic          pcie_read_ready, pcie_write_ready;
  logic          gpu_done, irq_clear, done_irq;

  int total = 0;
  int bad   = 0;

  gpu_host_bridge #(.MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .pcie_read_request(pcie_read_request), .pcie_write_request(pcie_write_request),
    .pcie_read_addr(pcie_read_addr), .pcie_write_addr(pcie_write_addr),
    .pcie_write_data(pcie_write_data), .pcie_read_ready(pcie_read_ready),
    .pcie_write_ready(pcie_write_ready), .pcie_read_data(pcie_read_data),
    .gpu_done(gpu_done), .irq_clear(irq_clear), .done_irq(done_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; pcie_read_ready = 1'b0; pcie_write_ready = 1'b0; pcie_read_data = '0;
    gpu_done = 1'b0; irq_clear = 1'b0;

    // ---- reset state
    repeat (2) tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rd_req", pcie_read_request, 0);
    chk("rst_wr_req", pcie_write_request, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_irq", done_irq, 0);
    reset_n = 1'b1;

    // ---- readies in IDLE are ignored
    pcie_read_ready = 1'b1; pcie_write_ready = 1'b1;
    tick();
    chk("idle_ign_cmd_ready", cmd_ready, 1);
    chk("idle_ign_rsp_valid", rsp_valid, 0);
    pcie_read_ready = 1'b0; pcie_write_ready = 1'b0;

    // ---- write, ready in the 3rd request cycle
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0004; cmd_wdata = 32'hDEADBEEF;
    tick();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'hFFFF; cmd_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_req", pcie_write_request, 1);
      chk("wr_no_rd_req", pcie_read_request, 0);
      chk("wr_addr", pcie_write_addr, 16'h0004);
      chk("wr_data", pcie_write_data, 32'hDEADBEEF);
      chk("wr_cmd_ready", cmd_ready, 0);
      chk("wr_rsp_valid", rsp_valid, 0);
      if (i == 2) pcie_write_ready = 1'b1;
      tick();
    end
    pcie_write_ready = 1'b0;
    chk("wr_rsp_valid1", rsp_valid, 1);
    chk("wr_rsp_error", rsp_error, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_req_drop", pcie_write_request, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("wr_back_idle", cmd_ready, 1);
    chk("wr_rsp_gone", rsp_valid, 0);

    // ---- read, ready already high in first request cycle
    cmd_valid = 1'b1; cmd_addr = 16'h0100;
    pcie_read_ready = 1'b1; pcie_read_data = 32'h12345678;
    tick();
    cmd_valid = 1'b0;
    chk("rd_req", pcie_read_request, 1);
    chk("rd_no_wr_req", pcie_write_request, 0);
    chk("rd_addr", pcie_read_addr, 16'h0100);
    tick();
    pcie_read_ready = 1'b0; pcie_read_data = 32'hCAFEF00D;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("rd_rsp_error", rsp_error, 0);
    chk("rd_req_drop", pcie_read_request, 0);

    // ---- backpressure: 5 cycles with rsp_ready low and a pending command
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0040; cmd_wdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 32'h12345678);
      chk("bp_error", rsp_error, 0);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_no_wr_req", pcie_write_request, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    chk("bp_idle_after", cmd_ready, 1);
    chk("bp_rsp_gone", rsp_valid, 0);
    chk("bp_not_accepted", pcie_write_request, 0);
    tick();
    chk("bp_still_idle", cmd_ready, 1);

    // ---- read that never sees ready
    cmd_valid = 1'b1; cmd_addr = 16'h0022;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk("to_req_high", pcie_read_request, 1);
      chk("to_no_rsp", rsp_valid, 0);
      tick();
    end
`ifdef GPU_HOST_BRIDGE_TIMEOUT_EN
    chk("to_req_drop", pcie_read_request, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_error", rsp_error, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
`else
    for (int i = 0; i < 4; i++) begin
      chk("noto_req_high", pcie_read_request, 1);
      chk("noto_no_rsp", rsp_valid, 0);
      chk("noto_error", rsp_error, 0);
      tick();
    end
    pcie_read_ready = 1'b1; pcie_read_data = 32'h0000A5A5;
    tick();
    pcie_read_ready = 1'b0;
    chk("noto_rsp_valid", rsp_valid, 1);
    chk("noto_rdata", rsp_rdata, 32'h0000A5A5);
    chk("noto_error_end", rsp_error, 0);
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("to_back_idle", cmd_ready, 1);

    // ---- interrupt: set beats simultaneous clear, level does not re-set
    gpu_done = 1'b1; irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    chk("irq_set_wins", done_irq, 1);
    tick();
    chk("irq_sticky", done_irq, 1);
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    chk("irq_cleared", done_irq, 0);
    repeat (3) tick();
    chk("irq_level_no_reset", done_irq, 0);
    gpu_done = 1'b0;
    tick();
    gpu_done = 1'b1;
    tick();
    chk("irq_second_rise", done_irq, 1);

    // ---- reset in the middle of a read
    cmd_valid = 1'b1; cmd_addr = 16'h0300;
    tick();
    cmd_valid = 1'b0;
    chk("mr_req_high", pcie_read_request, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_req_async_drop", pcie_read_request, 0);
    chk("mr_cmd_ready", cmd_ready, 1);
    chk("mr_irq_cleared", done_irq, 0);
    pcie_read_ready = 1'b1; pcie_read_data = 32'h55AA55AA;
    tick();
    tick();
    reset_n = 1'b1;
    pcie_read_ready = 1'b0;
    chk("mr_after_cmd_ready", cmd_ready, 1);
    chk("mr_after_rsp_valid", rsp_valid, 0);
    chk("mr_after_rdata", rsp_rdata, 0);
    tick();
    chk("mr_idle_hold", cmd_ready, 1);
    chk("mr_no_rsp", rsp_valid, 0);
    // registered gpu_done copy was cleared, so the held-high level reads as a rise
    chk("mr_irq_rise_after_rst", done_irq, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpu_host_bridge.md
GPU_HOST_BRIDGE -- requirements
Module: gpu_host_bridge

Interface
REQ-001 Parameter MEM_DATA_WIDTH, default 32: width of host write data, read data and the PCIe-side data buses.
REQ-002 Parameter MEM_ADDR_WIDTH, default 16: width of host and PCIe-side addresses.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum number of wait cycles for a PCIe-side ready; legal range 1..65535.
REQ-004 clock  in  1  the only clock; every flop is rising-edge on it.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  in  1  host command present.
REQ-007 cmd_ready  out  1  bridge accepts the command this cycle.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  MEM_ADDR_WIDTH  target address.
REQ-010 cmd_wdata  in  MEM_DATA_WIDTH  write data.
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  host consumes the response.
REQ-013 rsp_rdata  out  MEM_DATA_WIDTH  read data; 0 for writes and timeouts.
REQ-014 rsp_error  out  1  1 = transaction timed out.
REQ-015 pcie_read_request, pcie_write_request  out  1 each  request strobes to the GPU memory module.
REQ-016 pcie_read_addr, pcie_write_addr  out  MEM_ADDR_WIDTH  request addresses.
REQ-017 pcie_write_data  out  MEM_DATA_WIDTH  write payload.
REQ-018 pcie_read_ready, pcie_write_ready  in  1 each  completion indications from the GPU memory module.
REQ-019 pcie_read_data  in  MEM_DATA_WIDTH  read payload, valid when pcie_read_ready = 1.
REQ-020 gpu_done  in  1  GPU kernel-complete level.
REQ-021 irq_clear  in  1  host clears done_irq.
REQ-022 done_irq  out  1  sticky GPU-completion interrupt.

Function
REQ-023 The FSM SHALL have states IDLE, WR_REQ, RD_REQ, RESP.
REQ-024 cmd_ready SHALL be 1 exactly when the state is IDLE; the command is accepted on a cycle with cmd_valid and cmd_ready both 1.
REQ-025 On accept, address and data SHALL be registered and the next state SHALL be WR_REQ if cmd_write = 1, otherwise RD_REQ.
REQ-026 In WR_REQ, pcie_write_request SHALL be 1 with stable address and data until the first cycle pcie_write_ready = 1, then the FSM SHALL move to RESP with rsp_rdata = 0 and rsp_error = 0.
REQ-027 In RD_REQ, pcie_read_request SHALL be 1 with a stable address until the first cycle pcie_read_ready = 1; pcie_read_data SHALL be captured that cycle into rsp_rdata, with rsp_error = 0, and the FSM SHALL move to RESP.
REQ-028 A ready that is already 1 in the first request cycle SHALL complete the request, so the minimum latency from accept to rsp_valid is 2 cycles.
REQ-029 Ready inputs SHALL be ignored outside their matching request state; the two request strobes SHALL never both be 1.
REQ-030 In RESP, rsp_valid SHALL be 1 and rsp_rdata and rsp_error SHALL be held stable until rsp_ready = 1, then the FSM SHALL return to IDLE. There is no back-to-back overlap: the next accept is no earlier than the cycle after the handshake.
REQ-031 A rising edge of gpu_done, detected against a registered copy of gpu_done, SHALL set done_irq. irq_clear SHALL clear it. If a set and irq_clear occur in the same cycle, the set SHALL win.

Reset
REQ-032 While reset_n = 0, the state SHALL be IDLE and every output SHALL be 0 except cmd_ready, which SHALL be 1. The registered gpu_done copy SHALL be 0.
REQ-033 Reset asserted mid-transaction SHALL abort the transaction immediately with no response; any request strobe SHALL drop asynchronously.

Configuration
REQ-034 With macro GPU_HOST_BRIDGE_TIMEOUT_EN defined, a 16-bit wait counter SHALL clear on entry to WR_REQ or RD_REQ and increment each cycle without ready. When it reaches TIMEOUT_CYCLES, the request SHALL drop and the FSM SHALL go to RESP with rsp_error = 1 and rsp_rdata = 0.
REQ-035 Without GPU_HOST_BRIDGE_TIMEOUT_EN, no counter SHALL exist, WR_REQ and RD_REQ SHALL wait indefinitely, and rsp_error SHALL be constant 0.

Verification
REQ-036 Write: accept cmd_write=1, addr 0x0004, data 0xDEADBEEF; pcie_write_ready 3 cycles later -> pcie_write_request high with those values for 3 cycles, then rsp_valid=1, rsp_error=0.
REQ-037 Read: read of addr 0x0100 with pcie_read_ready=1 in the first request cycle, pcie_read_data=0x12345678 -> rsp_valid 2 cycles after accept, rsp_rdata=0x12345678.
REQ-038 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_error stable, cmd_ready=0, a new cmd_valid is not accepted.
REQ-039 Timeout (macro on, TIMEOUT_CYCLES=4): read that never gets ready -> request drops and rsp_error=1, rsp_rdata=0 after 4 wait cycles; with the macro off the request stays high.
REQ-040 IRQ: gpu_done 0->1 with irq_clear=1 in the same cycle -> done_irq=1; a later irq_clear alone -> done_irq=0; gpu_done held high does not set it again.
REQ-041 Reset mid-read: drop reset_n while in RD_REQ -> pcie_read_request=0 immediately, and after release cmd_ready=1 with rsp_valid=0.
